// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction word layout used by the fetch stage.
package cpu_pkg;

  localparam int unsigned PC_W   = 4;
  localparam int unsigned INSN_W = 8;
  localparam int unsigned OPC_W  = 4;

  localparam logic [OPC_W-1:0]  OPC_JMP  = 4'b1111;
  localparam logic [OPC_W-1:0]  OPC_JNC  = 4'b1110;
  localparam logic [INSN_W-1:0] NOP_WORD = 8'h00;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [PC_W-1:0]  imm;
  } insn_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: hold, load or increment (wrapping modulo 2**PC_W).
module pc_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (hold) begin
      pc_d = pc_q;
    end else if (load) begin
      pc_d = load_val;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Fetch stage: PC to ROM, ROM word to IR, JMP/JNC resolution with a one-bubble flush.
// Optional FETCH_SELF_JUMP_HALT_EN: a taken JMP to its own address halts the core.
module fetch_seq
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [INSN_W-1:0] rom_data,
  input  logic              carry_flag,
  input  logic              stall_in,
  output logic [PC_W-1:0]   rom_addr,
  output logic [INSN_W-1:0] ir_out,
  output logic              ir_valid,
  output logic              branch_taken,
  output logic              halt
);

  insn_t           ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            halt_q;
  logic            pc_hold, pc_load;
  logic [PC_W-1:0] pc;
  logic            is_jmp, is_jnc_taken;

  pc_reg u_pc_reg (
    .clk      (clock),
    .rst_n    (reset),
    .hold     (pc_hold),
    .load     (pc_load),
    .load_val (ir_q.imm),
    .pc       (pc)
  );

  // Decode only real instructions; a flushed slot can never branch.
  assign is_jmp       = ir_valid_q && (ir_q.opc == OPC_JMP);
  assign is_jnc_taken = ir_valid_q && (ir_q.opc == OPC_JNC) && !carry_flag;
  assign branch_taken = (is_jmp || is_jnc_taken) && !stall_in && !halt_q;

  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_hold    = 1'b1;
    pc_load    = 1'b0;
    if (halt_q) begin
      ir_valid_d = 1'b0;
    end else if (!stall_in) begin
      pc_hold = 1'b0;
      if (branch_taken) begin
        pc_load    = 1'b1;
        ir_d       = insn_t'(NOP_WORD);
        ir_pc_d    = pc;
        ir_valid_d = 1'b0;
      end else begin
        ir_d       = insn_t'(rom_data);
        ir_pc_d    = pc;
        ir_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q       <= insn_t'(NOP_WORD);
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef FETCH_SELF_JUMP_HALT_EN
  logic halt_d;
  logic self_jump;

  // JNC is excluded: only an unconditional jump to itself is a dead loop.
  assign self_jump = (ir_q.opc == OPC_JMP) && (ir_q.imm == ir_pc_q);

  always_comb begin
    halt_d = halt_q;
    if (branch_taken && self_jump) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  assign rom_addr = pc;
  assign ir_out   = INSN_W'(ir_q);
  assign ir_valid = ir_valid_q;
  assign halt     = halt_q;

endmodule
